abc_display_reg_arbiter: RTL and testbench

Two-requester AXI4-Lite master that shares the abc_display_ip S00_AXI register slave (four 32-bit registers at byte offsets 0x0/0x4/0x8/0xC) between a control requester (r0) and a frame-timing updater (r1).
- Each requester uses a simple req/ack register-access interface.
- The block arbitrates round-robin and runs one single-beat AXI4-Lite write or read at a time.
- It returns read data and response to the granted requester.

---
 rtl/abc_display_reg_arbiter_if.sv | 66 ++++++
 rtl/abc_display_reg_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_abc_display_reg_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/abc_display_reg_arbiter_if.sv
// Requester-side and AXI4-Lite master-side signal bundle for abc_display_reg_arbiter.
// The master modport is the arbiter's view; slave is the view of whoever sits on the other side.
interface abc_display_reg_arbiter_if #(
  parameter int C_AXI_ADDR_WIDTH = 4,
  parameter int C_AXI_DATA_WIDTH = 32
);
  // requester side, slice i belongs to requester i
  logic [1:0]                      req;
  logic [1:0]                      we;
  logic [2*C_AXI_ADDR_WIDTH-1:0]   addr;
  logic [2*C_AXI_DATA_WIDTH-1:0]   wdata;
  logic [1:0]                      ack;
  logic [C_AXI_DATA_WIDTH-1:0]     rdata;
  logic [1:0]                      resp;
  logic                            busy;

  logic [C_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr;
  logic [2:0]                      m_axi_awprot;
  logic                            m_axi_awvalid;
  logic                            m_axi_awready;
  logic [C_AXI_DATA_WIDTH-1:0]     m_axi_wdata;
  logic [C_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb;
  logic                            m_axi_wvalid;
  logic                            m_axi_wready;
  logic [1:0]                      m_axi_bresp;
  logic                            m_axi_bvalid;
  logic                            m_axi_bready;
  logic [C_AXI_ADDR_WIDTH-1:0]     m_axi_araddr;
  logic [2:0]                      m_axi_arprot;
  logic                            m_axi_arvalid;
  logic                            m_axi_arready;
  logic [C_AXI_DATA_WIDTH-1:0]     m_axi_rdata;
  logic [1:0]                      m_axi_rresp;
  logic                            m_axi_rvalid;
  logic                            m_axi_rready;

  modport master (
    input  req, we, addr, wdata,
    output ack, rdata, resp, busy,
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output req, we, addr, wdata,
    input  ack, rdata, resp, busy,
    input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/abc_display_reg_arbiter.sv
// Round-robin arbiter sharing the abc_display_ip AXI4-Lite register slave between
// a control requester (0) and a frame-timing updater (1); one single-beat access at a time.
module abc_display_reg_arbiter #(
  parameter int C_AXI_ADDR_WIDTH = 4,
  parameter int C_AXI_DATA_WIDTH = 32
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  abc_display_reg_arbiter_if.master  bus
);

  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int SW = C_AXI_DATA_WIDTH / 8;
  localparam logic [AW-1:0] ALIGN_MASK = {{(AW-2){1'b1}}, 2'b00};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_ACK   = 3'd5
  } state_t;

  state_t          r_state;
  logic            r_last_grant;
  logic            r_grant;
  logic            r_aw_done;
  logic            r_w_done;
  logic [1:0]      r_ack;
  logic [DW-1:0]   r_rdata;
  logic [1:0]      r_resp;
  logic            r_busy;
  logic [AW-1:0]   r_awaddr;
  logic [AW-1:0]   r_araddr;
  logic [DW-1:0]   r_wdata;
  logic            r_awvalid;
  logic            r_wvalid;
  logic            r_bready;
  logic            r_arvalid;
  logic            r_rready;

  logic            w_grant;
  logic            w_we_sel;
  logic [AW-1:0]   w_addr_sel;
  logic [AW-1:0]   w_addr_aligned;
  logic [DW-1:0]   w_wdata_sel;
  logic            w_aw_hs;
  logic            w_w_hs;
  logic            w_aw_fin;
  logic            w_w_fin;

  // On contention the requester that was not served last wins.
  always_comb begin
    w_grant = r_last_grant;
    case (bus.req)
      2'b01:   w_grant = 1'b0;
      2'b10:   w_grant = 1'b1;
      2'b11:   w_grant = ~r_last_grant;
      default: w_grant = r_last_grant;
    endcase
  end

  assign w_we_sel       = w_grant ? bus.we[1] : bus.we[0];
  assign w_addr_sel     = w_grant ? bus.addr[AW +: AW] : bus.addr[0 +: AW];
  assign w_wdata_sel    = w_grant ? bus.wdata[DW +: DW] : bus.wdata[0 +: DW];
  assign w_addr_aligned = w_addr_sel & ALIGN_MASK;

  // A channel counts as finished if it handshook earlier or is handshaking now.
  assign w_aw_hs  = r_awvalid & bus.m_axi_awready;
  assign w_w_hs   = r_wvalid & bus.m_axi_wready;
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done | w_w_hs;

  // Transaction FSM with all bus and requester outputs registered.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_ack        <= 2'b00;
      r_rdata      <= '0;
      r_resp       <= 2'b00;
      r_busy       <= 1'b0;
      r_awaddr     <= '0;
      r_araddr     <= '0;
      r_wdata      <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req != 2'b00) begin
            r_grant      <= w_grant;
            r_last_grant <= w_grant;
            r_busy       <= 1'b1;
            if (w_we_sel) begin
              r_awaddr  <= w_addr_aligned;
              r_wdata   <= w_wdata_sel;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= S_WADDR;
            end else begin
              r_araddr  <= w_addr_aligned;
              r_arvalid <= 1'b1;
              r_state   <= S_RADDR;
            end
          end
        end
        S_WADDR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_state  <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (bus.m_axi_bvalid) begin
            r_resp   <= bus.m_axi_bresp;
            r_bready <= 1'b0;
            r_ack    <= r_grant ? 2'b10 : 2'b01;
            r_state  <= S_ACK;
          end
        end
        S_RADDR: begin
          if (bus.m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (bus.m_axi_rvalid) begin
            r_rdata  <= bus.m_axi_rdata;
            r_resp   <= bus.m_axi_rresp;
            r_rready <= 1'b0;
            r_ack    <= r_grant ? 2'b10 : 2'b01;
            r_state  <= S_ACK;
          end
        end
        S_ACK: begin
          r_ack   <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ack     <= 2'b00;
          r_busy    <= 1'b0;
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b0;
          r_bready  <= 1'b0;
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack           = r_ack;
  assign bus.rdata         = r_rdata;
  assign bus.resp          = r_resp;
  assign bus.busy          = r_busy;
  assign bus.m_axi_awaddr  = r_awaddr;
  assign bus.m_axi_awprot  = 3'b000;
  assign bus.m_axi_awvalid = r_awvalid;
  assign bus.m_axi_wdata   = r_wdata;
  assign bus.m_axi_wstrb   = {SW{1'b1}};
  assign bus.m_axi_wvalid  = r_wvalid;
  assign bus.m_axi_bready  = r_bready;
  assign bus.m_axi_araddr  = r_araddr;
  assign bus.m_axi_arprot  = 3'b000;
  assign bus.m_axi_arvalid = r_arvalid;
  assign bus.m_axi_rready  = r_rready;

endmodule

// File: tb/tb_abc_display_reg_arbiter.sv
// Self-checking bench for abc_display_reg_arbiter: table of single accesses against a
// small register-slave model, plus hand sequences for fairness, back-pressure and reset abort.
module tb_abc_display_reg_arbiter;

  logic clk;
  logic rst;
  logic slv_rst;

  abc_display_reg_arbiter_if #(.C_AXI_ADDR_WIDTH(4), .C_AXI_DATA_WIDTH(32)) bus ();

  abc_display_reg_arbiter #(.C_AXI_ADDR_WIDTH(4), .C_AXI_DATA_WIDTH(32)) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // slave model controls
  int          aw_dly = 0;
  int          w_dly  = 0;
  int          aw_cnt;
  int          w_cnt;
  logic        bvalid_en;
  logic [1:0]  bresp_v;
  logic [1:0]  rresp_v;

  // slave model state
  logic [31:0] mem [0:3];
  logic        aw_got, w_got;
  logic [3:0]  aw_lat;
  logic [31:0] w_lat;
  logic [3:0]  ar_lat;
  logic [3:0]  last_awaddr, last_araddr;
  logic [31:0] last_wdata;
  logic [3:0]  last_wstrb;
  int          aw_hs_n, w_hs_n;

  // activity monitor
  int ack_n = 0;
  int aw_hi_n = 0;
  int w_hi_n = 0;

  logic        aw_hs, w_hs, wr_go;
  logic [3:0]  wr_a;
  logic [31:0] wr_d;

  assign bus.m_axi_awready = (aw_cnt >= aw_dly);
  assign bus.m_axi_wready  = (w_cnt >= w_dly);
  assign bus.m_axi_bvalid  = bvalid_en;
  assign bus.m_axi_bresp   = bresp_v;
  assign bus.m_axi_arready = 1'b1;
  assign bus.m_axi_rvalid  = 1'b1;
  assign bus.m_axi_rresp   = rresp_v;
  assign bus.m_axi_rdata   = mem[ar_lat[3:2]];

  assign aw_hs = bus.m_axi_awvalid && bus.m_axi_awready;
  assign w_hs  = bus.m_axi_wvalid && bus.m_axi_wready;
  assign wr_go = (aw_hs || aw_got) && (w_hs || w_got);
  assign wr_a  = aw_hs ? bus.m_axi_awaddr : aw_lat;
  assign wr_d  = w_hs ? bus.m_axi_wdata : w_lat;

  always @(posedge clk or posedge slv_rst) begin
    if (slv_rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= 32'h0;
    end else if (wr_go) begin
      mem[wr_a[3:2]] <= wr_d;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      aw_lat <= 4'h0; w_lat <= 32'h0; ar_lat <= 4'h0;
    end else begin
      if (aw_hs) begin
        aw_cnt <= 0; aw_lat <= bus.m_axi_awaddr; last_awaddr <= bus.m_axi_awaddr;
        aw_hs_n <= aw_hs_n + 1;
      end else if (bus.m_axi_awvalid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (w_hs) begin
        w_cnt <= 0; w_lat <= bus.m_axi_wdata; last_wdata <= bus.m_axi_wdata;
        last_wstrb <= bus.m_axi_wstrb; w_hs_n <= w_hs_n + 1;
      end else if (bus.m_axi_wvalid) begin
        w_cnt <= w_cnt + 1;
      end
      if (wr_go) begin
        aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
        ar_lat <= bus.m_axi_araddr; last_araddr <= bus.m_axi_araddr;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.ack != 2'b00) ack_n <= ack_n + 1;
    if (bus.m_axi_awvalid) aw_hi_n <= aw_hi_n + 1;
    if (bus.m_axi_wvalid)  w_hi_n  <= w_hi_n + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One access by requester id; called at a negedge while the arbiter is idle.
  task automatic access(input int id, input logic wr, input logic [3:0] a, input logic [31:0] d,
                        input logic [1:0] exp_resp, input logic [31:0] exp_rd,
                        input logic [3:0] exp_axa, input int exp_lat);
    int n;
    bus.we[id]             = wr;
    bus.addr[id*4 +: 4]    = a;
    bus.wdata[id*32 +: 32] = d;
    bus.req[id]            = 1'b1;
    @(posedge clk);
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) chk("busy_after_grant", bus.busy, 1);
      if (bus.ack != 2'b00) break;
    end
    chk("ack_latency", n, exp_lat);
    chk("ack_bits", bus.ack, (id == 1) ? 2'b10 : 2'b01);
    chk("busy_at_ack", bus.busy, 1);
    chk("rdata", bus.rdata, exp_rd);
    chk("resp", bus.resp, exp_resp);
    if (wr) begin
      chk("awaddr", last_awaddr, exp_axa);
      chk("wdata", last_wdata, d);
      chk("wstrb", last_wstrb, 4'hF);
    end else begin
      chk("araddr", last_araddr, exp_axa);
    end
    bus.req[id] = 1'b0;
    @(negedge clk);
    chk("ack_pulse_end", bus.ack, 2'b00);
    chk("busy_idle", bus.busy, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int          id;
    logic        wr;
    logic [3:0]  a;
    logic [31:0] d;
    logic [1:0]  sresp;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rd;
    logic [3:0]  exp_axa;
  } vec_t;

  vec_t       vt [9];
  logic [1:0] order [4];
  int         k, s_aw_hi, s_w_hi, s_aw_hs, s_w_hs, s_ack;

  initial begin
    vt[0] = '{0, 1'b1, 4'h4, 32'hDEADBEEF, 2'b00, 2'b00, 32'h00000000, 4'h4};
    vt[1] = '{1, 1'b1, 4'hC, 32'hA5A5A5A5, 2'b00, 2'b00, 32'h00000000, 4'hC};
    vt[2] = '{1, 1'b0, 4'hC, 32'h00000000, 2'b00, 2'b00, 32'hA5A5A5A5, 4'hC};
    vt[3] = '{0, 1'b0, 4'h7, 32'h00000000, 2'b00, 2'b00, 32'hDEADBEEF, 4'h4};
    vt[4] = '{0, 1'b1, 4'h0, 32'h00000011, 2'b00, 2'b00, 32'hDEADBEEF, 4'h0};
    vt[5] = '{1, 1'b0, 4'h2, 32'h00000000, 2'b00, 2'b00, 32'h00000011, 4'h0};
    vt[6] = '{0, 1'b0, 4'h8, 32'h00000000, 2'b00, 2'b00, 32'h00000000, 4'h8};
    vt[7] = '{1, 1'b1, 4'h8, 32'h00000022, 2'b11, 2'b11, 32'h00000000, 4'h8};
    vt[8] = '{0, 1'b0, 4'h8, 32'h00000000, 2'b10, 2'b10, 32'h00000022, 4'h8};

    clk = 1'b0; rst = 1'b1; slv_rst = 1'b1;
    bus.req = 2'b00; bus.we = 2'b00; bus.addr = 8'h00; bus.wdata = 64'h0;
    bvalid_en = 1'b1; bresp_v = 2'b00; rresp_v = 2'b00;
    repeat (2) @(negedge clk);
    slv_rst = 1'b0;

    chk("reset_outputs", {bus.ack, bus.busy, bus.resp, bus.rdata}, 0);
    chk("reset_valids", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
                         bus.m_axi_arvalid, bus.m_axi_rready}, 0);
    chk("reset_bus", {bus.m_axi_awaddr, bus.m_axi_araddr, bus.m_axi_wdata}, 0);
    chk("prot_const", {bus.m_axi_awprot, bus.m_axi_arprot}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      bresp_v = vt[i].wr ? vt[i].sresp : 2'b00;
      rresp_v = vt[i].wr ? 2'b00 : vt[i].sresp;
      access(vt[i].id, vt[i].wr, vt[i].a, vt[i].d, vt[i].exp_resp, vt[i].exp_rd, vt[i].exp_axa, 3);
    end
    bresp_v = 2'b00; rresp_v = 2'b00;

    // fairness: both write continuously after reset, acks must alternate starting with r0
    pulse_reset();
    bus.we = 2'b11; bus.addr = {4'h8, 4'h0}; bus.wdata = {32'h00000022, 32'h00000011};
    bus.req = 2'b11;
    k = 0;
    for (int c = 0; c < 80 && k < 4; c++) begin
      @(negedge clk);
      if (bus.ack != 2'b00) begin
        order[k] = bus.ack;
        k++;
      end
    end
    bus.req = 2'b00;
    @(negedge clk);
    chk("fair_ack_count", k, 4);
    for (int i = 0; i < 4; i++) chk("fair_order", order[i], (i % 2 == 1) ? 2'b10 : 2'b01);
    chk("fair_mem0", mem[0], 32'h00000011);
    chk("fair_mem2", mem[2], 32'h00000022);

    // back-pressure: awready after 3 cycles, wready after 1, SLVERR response
    aw_dly = 3; w_dly = 1; bresp_v = 2'b10;
    s_aw_hi = aw_hi_n; s_w_hi = w_hi_n; s_aw_hs = aw_hs_n; s_w_hs = w_hs_n;
    access(0, 1'b1, 4'h8, 32'h12345678, 2'b10, 32'h00000000, 4'h8, 6);
    chk("bp_awvalid_cycles", aw_hi_n - s_aw_hi, 4);
    chk("bp_wvalid_cycles", w_hi_n - s_w_hi, 2);
    chk("bp_aw_handshakes", aw_hs_n - s_aw_hs, 1);
    chk("bp_w_handshakes", w_hs_n - s_w_hs, 1);
    aw_dly = 0; w_dly = 0; bresp_v = 2'b00;

    // reset abort while waiting in WRESP
    access(1, 1'b0, 4'h4, 32'h0, 2'b00, 32'hDEADBEEF, 4'h4, 3);
    bvalid_en = 1'b0;
    bus.we[0] = 1'b1; bus.addr[3:0] = 4'hC; bus.wdata[31:0] = 32'h00000077;
    bus.req[0] = 1'b1;
    @(posedge clk);
    repeat (2) @(negedge clk);
    chk("abort_in_wresp", bus.m_axi_bready, 1);
    s_ack = ack_n;
    rst = 1'b1;
    #1;
    chk("abort_outputs", {bus.ack, bus.busy, bus.resp, bus.rdata}, 0);
    chk("abort_valids", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
                         bus.m_axi_arvalid, bus.m_axi_rready}, 0);
    chk("abort_bus", {bus.m_axi_awaddr, bus.m_axi_araddr, bus.m_axi_wdata}, 0);
    repeat (2) @(negedge clk);
    bus.req = 2'b00;
    bvalid_en = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_ack", ack_n - s_ack, 0);

    // contention right after reset favours r0
    bus.we = 2'b00; bus.addr = {4'h4, 4'h0};
    bus.req = 2'b11;
    k = 0;
    for (int c = 0; c < 20 && k < 1; c++) begin
      @(negedge clk);
      if (bus.ack != 2'b00) begin
        order[0] = bus.ack;
        k++;
      end
    end
    bus.req = 2'b00;
    @(negedge clk);
    chk("post_reset_first", (k == 1) ? order[0] : 2'b00, 2'b01);

    access(1, 1'b0, 4'h0, 32'h0, 2'b00, 32'h00000011, 4'h0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
